// File: rtl/sr_pkg.sv
// sr_pkg: shared mode constants and counting helpers for the SR flip-flop bank
package sr_pkg;
  localparam int MODE_HOLD = 0;
  localparam int MODE_SET  = 1;
  localparam int MODE_RST  = 2;
  localparam int MODE_TGL  = 3;
  localparam int MAX_W     = 256;
  function automatic int popcount(input logic [MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n += int'(v[i]);
    return n;
  endfunction
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] sum, lim;
    sum = a + b;
    lim = (64'(1) << w) - 64'(1);
    return (sum > lim) ? lim : sum;
  endfunction
endpackage

// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if: control inputs and state/status outputs of the SR flip-flop bank
interface sr_ff_bank_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] err;
  logic [CNT_W-1:0] err_cnt;
  modport master (output en, s, r, clr_err, input q, qb, chg, err, err_cnt);
  modport slave  (input en, s, r, clr_err, output q, qb, chg, err, err_cnt);
endinterface

// File: rtl/sr_ff_cell.sv
// sr_ff_cell: one enable-gated SR flip-flop channel with change pulse
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter int MODE = MODE_HOLD,
  parameter bit INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic chg
);
  logic q_nx;
  logic q_both;
  always_comb begin
    q_both = (MODE == MODE_SET) ? 1'b1 :
             (MODE == MODE_RST) ? 1'b0 :
             (MODE == MODE_TGL) ? ~q : q;
    q_nx   = !en      ? q      :
             (s && r) ? q_both :
             s        ? 1'b1   :
             r        ? 1'b0   : q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= INIT;
      chg <= 1'b0;
    end else begin
      q   <= q_nx;
      chg <= q_nx ^ q;
    end
  end
endmodule

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH-channel clocked SR flip-flop bank with sticky conflict flags and saturating conflict counter
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               MODE  = MODE_HOLD,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  sr_ff_bank_if.slave bus
);
  if (MODE < MODE_HOLD || MODE > MODE_TGL) begin : g_bad_mode
    $error("sr_ff_bank: MODE %0d is not one of 0..3", MODE);
  end
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] chg_w;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nx;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(.MODE(MODE), .INIT(INIT[i])) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (bus.en),
      .s   (bus.s[i]),
      .r   (bus.r[i]),
      .q   (q_w[i]),
      .chg (chg_w[i])
    );
  end
  // Conflicts are tallied in every mode, including the legal toggle case.
  always_comb begin
    c        = bus.s & bus.r & {WIDTH{bus.en}};
    cnt_base = bus.clr_err ? '0 : cnt_q;
    cnt_nx   = CNT_W'(sat_add(64'(cnt_base), 64'(popcount(MAX_W'(c))), CNT_W));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= (bus.clr_err ? '0 : err_q) | c;
      cnt_q <= cnt_nx;
    end
  end
  assign bus.q       = q_w;
  assign bus.qb      = ~q_w;
  assign bus.chg     = chg_w;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;
endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: directed vector check of all four conflict modes plus a 4-bit counter saturation instance
module tb_sr_ff_bank;
  typedef struct packed {
    logic        rst;
    logic        en;
    logic        clr;
    logic [7:0]  s;
    logic [7:0]  r;
    logic [31:0] q;
    logic [31:0] chg;
    logic [7:0]  err;
    logic [7:0]  cnt8;
    logic [7:0]  cnt4;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en, clr_err;
  logic [7:0] s, r;
  logic [7:0] q_a[5], qb_a[5], chg_a[5], err_a[5], cnt_a[5];
  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[14];

  always #5 clk = ~clk;

  // Instances 0..3 run MODE 0..3 with an 8-bit counter; instance 4 is MODE 0 with a 4-bit counter.
  for (genvar g = 0; g < 5; g++) begin : u
    sr_ff_bank_if #(.WIDTH(8), .CNT_W(g == 4 ? 4 : 8)) bus ();
    sr_ff_bank #(.WIDTH(8), .MODE(g % 4), .INIT(8'hA5), .CNT_W(g == 4 ? 4 : 8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.en      = en;
    assign bus.s       = s;
    assign bus.r       = r;
    assign bus.clr_err = clr_err;
    assign q_a[g]      = bus.q;
    assign qb_a[g]     = bus.qb;
    assign chg_a[g]    = bus.chg;
    assign err_a[g]    = bus.err;
    assign cnt_a[g]    = 8'(bus.err_cnt);
  end

  function automatic vec_t row(logic rs, logic e, logic cl, logic [7:0] sv, logic [7:0] rv,
                               logic [31:0] qv, logic [31:0] cv, logic [7:0] ev,
                               logic [7:0] c8, logic [7:0] c4);
    return '{rst: rs, en: e, clr: cl, s: sv, r: rv, q: qv, chg: cv, err: ev, cnt8: c8, cnt4: c4};
  endfunction

  task automatic check(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec%0d dut%0d %s: got %h expected %h", vectors, d, name, act, exp);
    end
  endtask

  task automatic apply(input logic rs, input logic e, input logic cl, input logic [7:0] sv, input logic [7:0] rv);
    rst = rs; en = e; clr_err = cl; s = sv; r = rv;
    @(posedge clk);
    #1;
    vectors++;
  endtask

  initial begin
    // q/chg columns are {mode3, mode2, mode1, mode0}
    tbl[0]  = row(1, 0, 0, 8'h00, 8'h00, 32'hA5A5A5A5, 32'h00000000, 8'h00, 8'd0,  8'd0);
    tbl[1]  = row(1, 1, 0, 8'hFF, 8'hFF, 32'hA5A5A5A5, 32'h00000000, 8'h00, 8'd0,  8'd0);
    tbl[2]  = row(0, 1, 0, 8'h0F, 8'hF0, 32'h0F0F0F0F, 32'hAAAAAAAA, 8'h00, 8'd0,  8'd0);
    tbl[3]  = row(0, 0, 0, 8'h00, 8'h00, 32'h0F0F0F0F, 32'h00000000, 8'h00, 8'd0,  8'd0);
    tbl[4]  = row(0, 0, 0, 8'hFF, 8'hFF, 32'h0F0F0F0F, 32'h00000000, 8'h00, 8'd0,  8'd0);
    tbl[5]  = row(0, 1, 0, 8'h03, 8'h03, 32'h0C0C0F0F, 32'h03030000, 8'h03, 8'd2,  8'd2);
    tbl[6]  = row(0, 0, 1, 8'h00, 8'h00, 32'h0C0C0F0F, 32'h00000000, 8'h00, 8'd0,  8'd0);
    tbl[7]  = row(0, 1, 0, 8'hFF, 8'hFF, 32'hF300FF0F, 32'hFF0CF000, 8'hFF, 8'd8,  8'd8);
    tbl[8]  = row(0, 1, 0, 8'hFF, 8'hFF, 32'h0C00FF0F, 32'hFF000000, 8'hFF, 8'd16, 8'd15);
    tbl[9]  = row(0, 1, 1, 8'h01, 8'h01, 32'h0D00FF0F, 32'h01000000, 8'h01, 8'd1,  8'd1);
    tbl[10] = row(0, 1, 1, 8'h00, 8'h00, 32'h0D00FF0F, 32'h00000000, 8'h00, 8'd0,  8'd0);
    tbl[11] = row(1, 1, 0, 8'hFF, 8'hFF, 32'hA5A5A5A5, 32'h00000000, 8'h00, 8'd0,  8'd0);
    tbl[12] = row(0, 1, 0, 8'h00, 8'hFF, 32'h00000000, 32'hA5A5A5A5, 8'h00, 8'd0,  8'd0);
    tbl[13] = row(0, 1, 0, 8'hFF, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 8'd0,  8'd0);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].s, tbl[i].r);
      for (int d = 0; d < 5; d++) begin
        logic [7:0] eq, ec;
        eq = tbl[i].q[8*(d%4) +: 8];
        ec = tbl[i].chg[8*(d%4) +: 8];
        check("q",       d, q_a[d],   eq);
        check("qb",      d, qb_a[d],  ~eq);
        check("chg",     d, chg_a[d], ec);
        check("err",     d, err_a[d], tbl[i].err);
        check("err_cnt", d, cnt_a[d], d == 4 ? tbl[i].cnt4 : tbl[i].cnt8);
      end
    end
    // Keep conflicting on every channel: the 4-bit counter must pin at 15, the 8-bit ones keep climbing.
    for (int k = 1; k <= 3; k++) begin
      apply(0, 1, 0, 8'hFF, 8'hFF);
      check("sat_cnt",  4, cnt_a[4], (8 * k > 15) ? 8'd15 : 8'(8 * k));
      check("wide_cnt", 0, cnt_a[0], 8'(8 * k));
      check("sat_err",  4, err_a[4], 8'hFF);
      check("tgl_q",    3, q_a[3],   (k % 2 == 1) ? 8'h00 : 8'hFF);
    end
    // Idle cycle after the toggling burst drops chg and leaves the sticky state alone.
    apply(0, 0, 0, 8'hFF, 8'hFF);
    check("idle_chg", 3, chg_a[3], 8'h00);
    check("idle_cnt", 4, cnt_a[4], 8'd15);
    check("idle_err", 0, err_a[0], 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
